// File: rtl/dcache_miss_ctrl_pkg.sv
// Shared types and constants for the data-cache miss/refill sequencer.
package dcache_miss_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WB_RD,
        WB_WR,
        FILL,
        DONE
    } miss_state_t;

    localparam int DC_LINE_WORDS = 4;
    localparam int DC_FLAG_VALID = 0;
    localparam int DC_FLAG_DIRTY = 1;

endpackage

// File: rtl/dcache_miss_ctrl.sv
// Data-cache miss sequencer: writes back a dirty LRU victim line, refills the
// line from the memory bus into the LRU way, then updates LRU and releases the
// pipeline. CAM/bus strobes decode from state; addresses and data are latched.
module dcache_miss_ctrl
    import dcache_miss_ctrl_pkg::*;
#(
    parameter int LINE_WORDS = DC_LINE_WORDS,
    parameter int FLAG_VALID = DC_FLAG_VALID,
    parameter int FLAG_DIRTY = DC_FLAG_DIRTY
) (
    input  logic        clk_core,
    input  logic        reset,
    input  logic        miss_req,
    input  logic [26:0] miss_addr,
    input  logic [16:0] lru_tag,
    input  logic [1:0]  lru_flags,
    output logic        busy,
    output logic        miss_done,
    output logic        cam_read_req,
    output logic [9:0]  cam_read_index,
    output logic [16:0] cam_read_tag,
    input  logic [31:0] cam_read_data,
    output logic        cam_write_req,
    output logic        cam_write_lru_way,
    output logic [1:0]  cam_write_offset,
    output logic [31:0] cam_write_data,
    output logic [3:0]  cam_write_mask,
    output logic [16:0] cam_write_tag,
    output logic [1:0]  cam_write_flags,
    output logic        cam_lru_update,
    output logic        bus_req,
    output logic        bus_we,
    output logic [26:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    // Counter is 2 bits wide because the CAM write offset is 2 bits.
    localparam logic [1:0] LAST_WORD         = 2'(LINE_WORDS - 1);
    localparam logic [1:0] FLAGS_VALID_CLEAN = 2'(1 << FLAG_VALID);

    miss_state_t state_q, state_d;
    logic [1:0]  word_q, word_d;
    logic [7:0]  set_q, set_d;
    logic [16:0] miss_tag_q, miss_tag_d;
    logic [16:0] victim_tag_q, victim_tag_d;
    logic        wb_first_q, wb_first_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] wb_word;
    logic        victim_dirty;

    assign victim_dirty = lru_flags[FLAG_VALID] & lru_flags[FLAG_DIRTY];

    // CAM read data arrives during the first WB_WR cycle; forward it then and
    // hold the captured copy for the remaining cycles of the bus write.
    assign wb_word = wb_first_q ? cam_read_data : wdata_q;

    // Next-state, word counter and address/data latch updates.
    always_comb begin
        state_d      = state_q;
        word_d       = word_q;
        set_d        = set_q;
        miss_tag_d   = miss_tag_q;
        victim_tag_d = victim_tag_q;
        wb_first_d   = (state_q == WB_RD);
        wdata_d      = wb_word;
        case (state_q)
            IDLE: begin
                if (miss_req) begin
                    set_d        = miss_addr[9:2];
                    miss_tag_d   = miss_addr[26:10];
                    victim_tag_d = lru_tag;
                    word_d       = 2'd0;
                    state_d      = victim_dirty ? WB_RD : FILL;
                end
            end
            WB_RD: state_d = WB_WR;
            WB_WR: begin
                if (bus_ack) begin
                    if (word_q == LAST_WORD) begin
                        word_d  = 2'd0;
                        state_d = FILL;
                    end else begin
                        word_d  = word_q + 2'd1;
                        state_d = WB_RD;
                    end
                end
            end
            FILL: begin
                if (bus_ack) begin
                    if (word_q == LAST_WORD) begin
                        word_d  = 2'd0;
                        state_d = DONE;
                    end else begin
                        word_d  = word_q + 2'd1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control state: reset aborts any miss in progress.
    always_ff @(posedge clk_core) begin
        if (reset) begin
            state_q    <= IDLE;
            word_q     <= 2'd0;
            wb_first_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            wb_first_q <= wb_first_d;
        end
    end

    // Address/data latches; only observed through state-gated outputs.
    always_ff @(posedge clk_core) begin
        set_q        <= set_d;
        miss_tag_q   <= miss_tag_d;
        victim_tag_q <= victim_tag_d;
        wdata_q      <= wdata_d;
    end

    // Output decode from state; everything is zero outside its own state.
    always_comb begin
        busy              = (state_q != IDLE);
        miss_done         = 1'b0;
        cam_read_req      = 1'b0;
        cam_read_index    = '0;
        cam_read_tag      = '0;
        cam_write_req     = 1'b0;
        cam_write_lru_way = 1'b0;
        cam_write_offset  = '0;
        cam_write_data    = '0;
        cam_write_mask    = '0;
        cam_write_tag     = '0;
        cam_write_flags   = '0;
        cam_lru_update    = 1'b0;
        bus_req           = 1'b0;
        bus_we            = 1'b0;
        bus_addr          = '0;
        bus_wdata         = '0;
        case (state_q)
            WB_RD: begin
                cam_read_req   = 1'b1;
                cam_read_index = {set_q, word_q};
                cam_read_tag   = victim_tag_q;
            end
            WB_WR: begin
                bus_req   = 1'b1;
                bus_we    = 1'b1;
                bus_addr  = {victim_tag_q, set_q, word_q};
                bus_wdata = wb_word;
            end
            FILL: begin
                bus_req  = 1'b1;
                bus_addr = {miss_tag_q, set_q, word_q};
                if (bus_ack) begin
                    cam_write_req     = 1'b1;
                    cam_write_lru_way = 1'b1;
                    cam_write_offset  = word_q;
                    cam_write_data    = bus_rdata;
                    cam_write_mask    = 4'hF;
                    cam_write_tag     = miss_tag_q;
                    // Line becomes valid only with its last word.
                    cam_write_flags   = (word_q == LAST_WORD) ? FLAGS_VALID_CLEAN : 2'b00;
                end
            end
            DONE: begin
                cam_lru_update = 1'b1;
                miss_done      = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// Scoreboard bench for dcache_miss_ctrl: a bus/CAM agent answers requests and
// compares every CAM read, bus transfer and CAM write against queued expectations.
module tb_dcache_miss_ctrl;

    typedef struct {
        logic        we;
        logic [26:0] addr;
        logic [31:0] wdata;
    } bus_t;

    typedef struct {
        logic [9:0]  idx;
        logic [16:0] tag;
    } rd_t;

    typedef struct {
        logic [1:0]  off;
        logic [31:0] data;
        logic [1:0]  flags;
        logic [16:0] tag;
    } cw_t;

    logic        clk_core = 1'b0;
    logic        reset = 1'b1;
    logic        miss_req = 1'b0;
    logic [26:0] miss_addr = '0;
    logic [16:0] lru_tag = '0;
    logic [1:0]  lru_flags = '0;
    logic        busy, miss_done, cam_read_req, cam_write_req, cam_write_lru_way;
    logic        cam_lru_update, bus_req, bus_we;
    logic [9:0]  cam_read_index;
    logic [16:0] cam_read_tag, cam_write_tag;
    logic [31:0] cam_read_data = '0;
    logic [1:0]  cam_write_offset, cam_write_flags;
    logic [31:0] cam_write_data, bus_wdata;
    logic [3:0]  cam_write_mask;
    logic [26:0] bus_addr;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = '0;
    logic [150:0] all_out;

    bus_t exp_bus[$];
    rd_t  exp_rd[$];
    cw_t  exp_cw[$];

    int   n_checks = 0;
    int   n_pass = 0;
    int   bus_lat = 2;
    logic stray_ack = 1'b0;

    dcache_miss_ctrl dut (
        .clk_core(clk_core), .reset(reset), .miss_req(miss_req), .miss_addr(miss_addr),
        .lru_tag(lru_tag), .lru_flags(lru_flags), .busy(busy), .miss_done(miss_done),
        .cam_read_req(cam_read_req), .cam_read_index(cam_read_index),
        .cam_read_tag(cam_read_tag), .cam_read_data(cam_read_data),
        .cam_write_req(cam_write_req), .cam_write_lru_way(cam_write_lru_way),
        .cam_write_offset(cam_write_offset), .cam_write_data(cam_write_data),
        .cam_write_mask(cam_write_mask), .cam_write_tag(cam_write_tag),
        .cam_write_flags(cam_write_flags), .cam_lru_update(cam_lru_update),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    assign all_out = {busy, miss_done, cam_read_req, cam_read_index, cam_read_tag,
                      cam_write_req, cam_write_lru_way, cam_write_offset, cam_write_data,
                      cam_write_mask, cam_write_tag, cam_write_flags, cam_lru_update,
                      bus_req, bus_we, bus_addr, bus_wdata};

    initial forever #5 clk_core = ~clk_core;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] cam_model(input logic [16:0] tag, input logic [9:0] idx);
        return {5'b10101, tag, idx};
    endfunction

    function automatic logic [31:0] bus_model(input logic [26:0] a);
        return {5'b01010, a} ^ 32'h00FF_00FF;
    endfunction

    // Memory bus and CAM responder plus output monitor.
    initial begin : agent
        int          cnt = 0;
        logic        pend = 1'b0;
        logic [9:0]  pidx = '0;
        logic [16:0] ptag = '0;
        logic        hold = 1'b0;
        logic [26:0] haddr = '0;
        logic        hwe = 1'b0;
        bus_t        b;
        rd_t         r;
        cw_t         c;
        forever begin
            @(posedge clk_core);
            #1;
            cam_read_data = pend ? cam_model(ptag, pidx) : 32'hDEAD_BEEF;
            if (bus_req) begin
                if (cnt >= bus_lat) begin
                    bus_ack   = 1'b1;
                    bus_rdata = bus_model(bus_addr);
                    cnt       = 0;
                end else begin
                    bus_ack   = 1'b0;
                    bus_rdata = $urandom;
                    cnt++;
                end
            end else begin
                cnt       = 0;
                bus_ack   = stray_ack;
                bus_rdata = $urandom;
            end
            @(negedge clk_core);
            if (cam_read_req) begin
                n_checks++;
                if (exp_rd.size() == 0) begin
                    $display("FAIL cam_read_unexpected: idx=%h tag=%h, expected no read", cam_read_index, cam_read_tag);
                end else begin
                    r = exp_rd.pop_front();
                    if ({cam_read_index, cam_read_tag} !== {r.idx, r.tag})
                        $display("FAIL cam_read: idx=%h tag=%h, expected idx=%h tag=%h", cam_read_index, cam_read_tag, r.idx, r.tag);
                    else n_pass++;
                end
            end
            if (hold && bus_req && !reset) begin
                n_checks++;
                if ({bus_we, bus_addr} !== {hwe, haddr})
                    $display("FAIL bus_stable: we=%b addr=%h, expected we=%b addr=%h", bus_we, bus_addr, hwe, haddr);
                else n_pass++;
            end
            if (bus_req && bus_ack) begin
                n_checks++;
                if (exp_bus.size() == 0) begin
                    $display("FAIL bus_unexpected: we=%b addr=%h, expected no transfer", bus_we, bus_addr);
                end else begin
                    b = exp_bus.pop_front();
                    if (bus_we !== b.we || bus_addr !== b.addr || (b.we && bus_wdata !== b.wdata))
                        $display("FAIL bus_xfer: we=%b addr=%h wdata=%h, expected we=%b addr=%h wdata=%h",
                                 bus_we, bus_addr, bus_wdata, b.we, b.addr, b.wdata);
                    else n_pass++;
                end
            end
            if (cam_write_req) begin
                n_checks++;
                if (exp_cw.size() == 0) begin
                    $display("FAIL cam_write_unexpected: off=%0d data=%h, expected no write", cam_write_offset, cam_write_data);
                end else begin
                    c = exp_cw.pop_front();
                    if ({cam_write_offset, cam_write_data, cam_write_flags, cam_write_tag, cam_write_mask, cam_write_lru_way}
                        !== {c.off, c.data, c.flags, c.tag, 4'hF, 1'b1})
                        $display("FAIL cam_write: off=%0d data=%h flags=%b tag=%h mask=%h way=%b, expected off=%0d data=%h flags=%b tag=%h mask=f way=1",
                                 cam_write_offset, cam_write_data, cam_write_flags, cam_write_tag, cam_write_mask,
                                 cam_write_lru_way, c.off, c.data, c.flags, c.tag);
                    else n_pass++;
                end
            end
            pend  = cam_read_req;
            pidx  = cam_read_index;
            ptag  = cam_read_tag;
            hold  = bus_req && !bus_ack;
            haddr = bus_addr;
            hwe   = bus_we;
        end
    end

    // Queue the transfers a miss is expected to produce, in order.
    task automatic push_miss(input logic [26:0] addr, input logic [16:0] vtag, input logic [1:0] flags);
        logic [7:0]  set;
        logic [16:0] mtag;
        logic [1:0]  w2;
        bus_t        b;
        rd_t         r;
        cw_t         c;
        set  = addr[9:2];
        mtag = addr[26:10];
        if (flags == 2'b11) begin
            for (int w = 0; w < 4; w++) begin
                w2      = w[1:0];
                r.idx   = {set, w2};
                r.tag   = vtag;
                exp_rd.push_back(r);
                b.we    = 1'b1;
                b.addr  = {vtag, set, w2};
                b.wdata = cam_model(vtag, {set, w2});
                exp_bus.push_back(b);
            end
        end
        for (int w = 0; w < 4; w++) begin
            w2      = w[1:0];
            b.we    = 1'b0;
            b.addr  = {mtag, set, w2};
            b.wdata = '0;
            exp_bus.push_back(b);
            c.off   = w2;
            c.data  = bus_model({mtag, set, w2});
            c.flags = (w == 3) ? 2'b01 : 2'b00;
            c.tag   = mtag;
            exp_cw.push_back(c);
        end
    endtask

    // Drive one miss and wait for miss_done; cyc counts cycles after the miss_req cycle.
    task automatic do_miss(input logic [26:0] addr, input logic [16:0] vtag, input logic [1:0] flags,
                           input int lat, input logic pulse, output int cyc, output logic got_done,
                           output logic lru_at_done, output logic breq_at_done, output logic busy_gap,
                           output logic busy_after);
        bus_lat  = lat;
        busy_gap = 1'b0;
        push_miss(addr, vtag, flags);
        @(negedge clk_core);
        miss_req  = 1'b1;
        miss_addr = addr;
        lru_tag   = vtag;
        lru_flags = flags;
        @(negedge clk_core);
        miss_req = 1'b0;
        cyc = 1;
        while (!miss_done && cyc < 300) begin
            if (!busy) busy_gap = 1'b1;
            @(negedge clk_core);
            cyc++;
            if (pulse && cyc == 4) begin
                miss_req  = 1'b1;
                miss_addr = 27'h7FF_FFFF;
                lru_tag   = 17'h1FFFF;
                lru_flags = 2'b11;
            end else begin
                miss_req = 1'b0;
            end
        end
        miss_req     = 1'b0;
        got_done     = miss_done;
        lru_at_done  = cam_lru_update;
        breq_at_done = bus_req;
        @(negedge clk_core);
        busy_after = busy | miss_done;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk_core);
        n_checks++;
        if (all_out !== '0) $display("FAIL reset_outputs: got %h, expected 0", all_out);
        else n_pass++;
        reset = 1'b0;
        repeat (2) @(negedge clk_core);
        n_checks++;
        if (busy !== 1'b0) $display("FAIL reset_idle_busy: got %b, expected 0", busy);
        else n_pass++;
        n_checks++;
        if (all_out !== '0) $display("FAIL reset_idle_outputs: got %h, expected 0", all_out);
        else n_pass++;
    endtask

    task automatic test_clean_miss();
        int cyc; logic d, l, br, g, ba;
        do_miss(27'h0012345, 17'h00AAA, 2'b00, 2, 1'b0, cyc, d, l, br, g, ba);
        n_checks++;
        if (!(d === 1'b1 && l === 1'b1)) $display("FAIL clean_done: done=%b lru=%b, expected 1 1", d, l);
        else n_pass++;
        n_checks++;
        if (cyc !== 4 * (2 + 1) + 1) $display("FAIL clean_latency: got %0d, expected %0d", cyc, 4 * 3 + 1);
        else n_pass++;
        n_checks++;
        if (ba !== 1'b0 || g !== 1'b0) $display("FAIL clean_busy: after=%b gap=%b, expected 0 0", ba, g);
        else n_pass++;
        n_checks++;
        if (exp_bus.size() + exp_cw.size() + exp_rd.size() != 0)
            $display("FAIL clean_drain: got %0d pending, expected 0", exp_bus.size() + exp_cw.size() + exp_rd.size());
        else n_pass++;
    endtask

    task automatic test_dirty_victim();
        int cyc; logic d, l, br, g, ba;
        do_miss(27'h2B4C5D8, 17'h1ABCD, 2'b11, 2, 1'b0, cyc, d, l, br, g, ba);
        n_checks++;
        if (cyc !== 4 * 3 + 1 + 4 * 4 || d !== 1'b1)
            $display("FAIL dirty_latency: got %0d done=%b, expected %0d done=1", cyc, d, 4 * 3 + 1 + 4 * 4);
        else n_pass++;
        n_checks++;
        if (exp_bus.size() + exp_cw.size() + exp_rd.size() != 0 || ba !== 1'b0)
            $display("FAIL dirty_drain: got %0d pending busy=%b, expected 0 0", exp_bus.size() + exp_cw.size() + exp_rd.size(), ba);
        else n_pass++;
    endtask

    task automatic test_valid_clean_victim();
        int cyc; logic d, l, br, g, ba;
        do_miss(27'h0F0F0F1, 17'h0BEEF, 2'b01, 1, 1'b0, cyc, d, l, br, g, ba);
        n_checks++;
        if (cyc !== 4 * 2 + 1 || d !== 1'b1) $display("FAIL valid_clean_latency: got %0d, expected %0d", cyc, 4 * 2 + 1);
        else n_pass++;
        do_miss(27'h0333330, 17'h00123, 2'b10, 1, 1'b0, cyc, d, l, br, g, ba);
        n_checks++;
        if (cyc !== 4 * 2 + 1 || d !== 1'b1) $display("FAIL invalid_dirty_latency: got %0d, expected %0d", cyc, 4 * 2 + 1);
        else n_pass++;
    endtask

    task automatic test_reset_mid_fill();
        int  n;
        logic found;
        bus_lat = 2;
        push_miss(27'h0055554, 17'h00000, 2'b00);
        @(negedge clk_core);
        miss_req  = 1'b1;
        miss_addr = 27'h0055554;
        lru_flags = 2'b00;
        @(negedge clk_core);
        miss_req = 1'b0;
        n = 0;
        found = 1'b0;
        while (!found && n < 100) begin
            if (bus_req && !bus_we && bus_addr[1:0] == 2'd2) found = 1'b1;
            else begin
                @(negedge clk_core);
                n++;
            end
        end
        n_checks++;
        if (!found) $display("FAIL reset_fill_reach: got timeout, expected FILL word 2");
        else n_pass++;
        reset = 1'b1;
        @(negedge clk_core);
        n_checks++;
        if (all_out !== '0) $display("FAIL reset_fill_outputs: got %h, expected 0", all_out);
        else n_pass++;
        reset = 1'b0;
        n_checks++;
        if (exp_cw.size() != 2 || exp_bus.size() != 2)
            $display("FAIL reset_fill_progress: got cw=%0d bus=%0d left, expected 2 2", exp_cw.size(), exp_bus.size());
        else n_pass++;
        exp_cw.delete();
        exp_bus.delete();
        repeat (4) @(negedge clk_core);
        n_checks++;
        if (busy !== 1'b0 || bus_req !== 1'b0) $display("FAIL reset_fill_idle: busy=%b req=%b, expected 0 0", busy, bus_req);
        else n_pass++;
    endtask

    task automatic test_busy_ignore_stray_ack();
        int cyc; logic d, l, br, g, ba;
        logic bad;
        do_miss(27'h1234567, 17'h01111, 2'b00, 2, 1'b1, cyc, d, l, br, g, ba);
        n_checks++;
        if (cyc !== 13 || d !== 1'b1 || ba !== 1'b0)
            $display("FAIL busy_ignore: got cyc=%0d busy_after=%b, expected 13 0", cyc, ba);
        else n_pass++;
        bad = 1'b0;
        stray_ack = 1'b1;
        repeat (6) begin
            @(negedge clk_core);
            if (busy || bus_req || cam_write_req || cam_read_req) bad = 1'b1;
        end
        stray_ack = 1'b0;
        n_checks++;
        if (bad !== 1'b0) $display("FAIL stray_ack: got activity=%b, expected 0", bad);
        else n_pass++;
        do_miss(27'h0012345, 17'h1ABCD, 2'b11, 1, 1'b0, cyc, d, l, br, g, ba);
        n_checks++;
        if (cyc !== 4 * 2 + 1 + 4 * 3 || exp_bus.size() + exp_cw.size() + exp_rd.size() != 0)
            $display("FAIL after_stray: got cyc=%0d pending=%0d, expected %0d 0", cyc,
                     exp_bus.size() + exp_cw.size() + exp_rd.size(), 4 * 2 + 1 + 4 * 3);
        else n_pass++;
    endtask

    task automatic test_zero_wait();
        int cyc; logic d, l, br, g, ba;
        do_miss(27'h0000ABC, 17'h00777, 2'b00, 0, 1'b0, cyc, d, l, br, g, ba);
        n_checks++;
        if (cyc !== 4 * 1 + 1 || l !== 1'b1) $display("FAIL zero_wait_latency: got %0d, expected %0d", cyc, 5);
        else n_pass++;
        n_checks++;
        if (br !== 1'b0) $display("FAIL zero_wait_req_in_done: got %b, expected 0", br);
        else n_pass++;
        do_miss(27'h3FFFFFF, 17'h1ABCD, 2'b11, 0, 1'b0, cyc, d, l, br, g, ba);
        n_checks++;
        if (cyc !== 4 * 1 + 1 + 4 * 2 || br !== 1'b0 || ba !== 1'b0)
            $display("FAIL zero_wait_dirty: got cyc=%0d req=%b busy=%b, expected %0d 0 0", cyc, br, ba, 13);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_clean_miss();
        test_dirty_victim();
        test_valid_clean_victim();
        test_reset_mid_fill();
        test_busy_ignore_stray_ack();
        test_zero_wait();
        repeat (3) @(negedge clk_core);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
